ctrl_sequencer: RTL and testbench
=================================

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the immediate path.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port clear  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to run one operation; accepted only when ready=1.
REQ-005 SHALL have port opcode  input  2  operation select: 00 LDA, 01 ADDI, 10 MOVZB, 11 CHAIN.
REQ-006 SHALL have port imm  input  DATA_W  immediate operand, captured on accept.
REQ-007 SHALL have port ready  output  1  high in IDLE only.
REQ-008 SHALL have port RegisterAImmediate  output  DATA_W  immediate value driven to RA load path.
REQ-009 SHALL have port AddImmediate  output  DATA_W  immediate value driven to the adder.
REQ-010 SHALL have ports RAout, RBout, RZout  output  1 each  bus-drive enables to the datapath.
REQ-011 SHALL have ports RAin, RBin, RZin  output  1 each  register-load enables to the datapath.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, T0, T1, T2, DONE with registered (Moore) outputs.
REQ-014 Accept = start & ready at a rising edge; SHALL latch opcode and imm on accept; start while not ready SHALL be ignored with no effect.
REQ-015 On accept, the next state SHALL be: LDA->T0, ADDI->T1, MOVZB->T2, CHAIN->T0.
REQ-016 Each T-state SHALL last exactly one cycle; LDA, ADDI and MOVZB SHALL go from their T-state to DONE; CHAIN SHALL go T0->T1->T2->DONE.
REQ-017 In T0: RAin=1 and RegisterAImmediate=latched imm; all other enables 0.
REQ-018 In T1: RAout=1, RZin=1 and AddImmediate=latched imm; all other enables 0.
REQ-019 In T2: RZout=1, RBin=1; all other enables 0.
REQ-020 RegisterAImmediate and AddImmediate SHALL be 0 in every state other than T0 and T1 respectively.
REQ-021 DONE SHALL last one cycle with done=1 and all enables 0, then return to IDLE; ready SHALL be 0 in DONE.
REQ-022 At most one of RAout, RBout, RZout SHALL be 1 in any cycle.
REQ-023 Latency from accept edge to done=1: LDA, ADDI and MOVZB 2 cycles; CHAIN 4 cycles.
REQ-024 Back-to-back: start held high SHALL be re-accepted on the first cycle back in IDLE, giving a minimum accept spacing of 3 cycles for single-step operations.
REQ-025 RBout SHALL be held 0 in all states (reserved for future opcodes).

Reset
REQ-026 Asserting clear SHALL immediately force state IDLE, all enables 0, both immediate outputs 0, done=0, the latched opcode and imm to 0, and ready=1.
REQ-027 clear asserted mid-operation SHALL abort without completing the remaining T-states and without a done pulse.
REQ-028 After clear deasserts, the first accept SHALL be possible on the next rising edge.

Configuration
REQ-029 Macro CTRL_SEQ_STEP_EN: when defined, SHALL add input port step (1 bit) after opcode; each T-state and DONE SHALL advance only on an edge with step=1 and otherwise hold with outputs held; IDLE accept SHALL not depend on step.
REQ-030 Without CTRL_SEQ_STEP_EN, the step port SHALL not exist and states SHALL advance every cycle per REQ-016.

Verification
REQ-031 clear pulse with start=1 -> all outputs 0, ready=1, no accept until clear is low.
REQ-032 LDA, imm=0x5 -> next cycle RAin=1, RegisterAImmediate=0x5 for exactly 1 cycle; done=1 two cycles after accept.
REQ-033 CHAIN, imm=0x5 -> T0 (RAin, RegisterAImmediate=0x5), T1 (RAout, RZin, AddImmediate=0x5), T2 (RZout, RBin), then done; done=1 four cycles after accept.
REQ-034 start pulsed in T1 of CHAIN with opcode=00 -> ignored; sequence and latched imm unchanged.
REQ-035 clear asserted during T1 of CHAIN -> outputs 0 the same cycle, no T2, no done.
REQ-036 With CTRL_SEQ_STEP_EN, ADDI and step=0 for 3 cycles -> T1 outputs held; step=1 -> DONE next cycle.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
//
// Purpose:
//   Small micro-sequencer that runs one datapath operation per accepted start
//   request. It steps through up to three control phases (T0/T1/T2) and then
//   emits a one-cycle done pulse. All outputs are registered (Moore style).
//   The registers are loaded from the next-state decode, so each output
//   changes on the same edge as the state it belongs to.
//
// Optional feature:
//   CTRL_SEQ_STEP_EN - when defined, adds the 'step' input. T-states and DONE
//                      advance only on edges where step=1 and otherwise hold
//                      with their outputs unchanged. Accept from IDLE does not
//                      depend on step. When the macro is undefined, the port
//                      does not exist and states advance every cycle.
//
// Ports:
//   clk                 in   system clock, rising edge
//   clear               in   asynchronous active-high reset
//   start               in   run request, taken only while ready=1
//   opcode[1:0]         in   00 LDA, 01 ADDI, 10 MOVZB, 11 CHAIN
//   step                in   single-step enable (CTRL_SEQ_STEP_EN only)
//   imm[DATA_W-1:0]     in   immediate operand, captured on accept
//   ready               out  high in IDLE only
//   RegisterAImmediate  out  latched imm during T0, else 0
//   AddImmediate        out  latched imm during T1, else 0
//   RAout/RBout/RZout   out  bus-drive enables (RBout is reserved and tied 0)
//   RAin/RBin/RZin      out  register-load enables
//   done                out  one-cycle completion pulse
//
// States:
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start; ready=1
//   T0     | load RA from the immediate (RAin, RegisterAImmediate)
//   T1     | RA onto the bus, add the immediate, load RZ (RAout, RZin)
//   T2     | RZ onto the bus, load RB (RZout, RBin)
//   DONE   | done=1 for one cycle, then back to IDLE
// ---------------------------------------------------------------------------
module ctrl_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [1:0]        opcode,
`ifdef CTRL_SEQ_STEP_EN
    input  logic              step,
`endif
    input  logic [DATA_W-1:0] imm,
    output logic              ready,
    output logic [DATA_W-1:0] RegisterAImmediate,
    output logic [DATA_W-1:0] AddImmediate,
    output logic              RAout,
    output logic              RBout,
    output logic              RZout,
    output logic              RAin,
    output logic              RBin,
    output logic              RZin,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] OP_LDA   = 2'b00;
    localparam logic [1:0] OP_ADDI  = 2'b01;
    localparam logic [1:0] OP_MOVZB = 2'b10;
    localparam logic [1:0] OP_CHAIN = 2'b11;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        op_q;
    logic [1:0]        op_nxt;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] imm_nxt;
    logic              accept;
    logic              advance;

    // Next values of the registered outputs.
    logic              ready_nxt;
    logic [DATA_W-1:0] ra_imm_nxt;
    logic [DATA_W-1:0] add_imm_nxt;
    logic              ra_out_nxt;
    logic              rz_out_nxt;
    logic              ra_in_nxt;
    logic              rb_in_nxt;
    logic              rz_in_nxt;
    logic              done_nxt;

    // ready is only ever 1 while in IDLE, so this is the accept condition.
    assign accept = start & ready;

`ifdef CTRL_SEQ_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    // RB is never driven onto the bus by the current opcode set.
    assign RBout = 1'b0;

    // ------------------------------------------------------------------
    // State register, operand latches and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state              <= S_IDLE;
            op_q               <= '0;
            imm_q              <= '0;
            ready              <= 1'b1;
            RegisterAImmediate <= '0;
            AddImmediate       <= '0;
            RAout              <= 1'b0;
            RZout              <= 1'b0;
            RAin               <= 1'b0;
            RBin               <= 1'b0;
            RZin               <= 1'b0;
            done               <= 1'b0;
        end else begin
            state              <= state_nxt;
            op_q               <= op_nxt;
            imm_q              <= imm_nxt;
            ready              <= ready_nxt;
            RegisterAImmediate <= ra_imm_nxt;
            AddImmediate       <= add_imm_nxt;
            RAout              <= ra_out_nxt;
            RZout              <= rz_out_nxt;
            RAin               <= ra_in_nxt;
            RBin               <= rb_in_nxt;
            RZin               <= rz_in_nxt;
            done               <= done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        imm_nxt   = imm_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    op_nxt  = opcode;
                    imm_nxt = imm;
                    case (opcode)
                        OP_LDA:   state_nxt = S_T0;
                        OP_ADDI:  state_nxt = S_T1;
                        OP_MOVZB: state_nxt = S_T2;
                        OP_CHAIN: state_nxt = S_T0;
                        default:  state_nxt = S_IDLE;
                    endcase
                end
            end
            S_T0: begin
                if (advance) begin
                    state_nxt = (op_q == OP_CHAIN) ? S_T1 : S_DONE;
                end
            end
            S_T1: begin
                if (advance) begin
                    state_nxt = (op_q == OP_CHAIN) ? S_T2 : S_DONE;
                end
            end
            S_T2: begin
                if (advance) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (advance) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state. imm_nxt already holds the freshly
    // captured operand on the accept edge, so T0/T1 show it immediately.
    // ------------------------------------------------------------------
    always_comb begin
        ready_nxt   = 1'b0;
        ra_imm_nxt  = '0;
        add_imm_nxt = '0;
        ra_out_nxt  = 1'b0;
        rz_out_nxt  = 1'b0;
        ra_in_nxt   = 1'b0;
        rb_in_nxt   = 1'b0;
        rz_in_nxt   = 1'b0;
        done_nxt    = 1'b0;
        case (state_nxt)
            S_IDLE: begin
                ready_nxt = 1'b1;
            end
            S_T0: begin
                ra_in_nxt  = 1'b1;
                ra_imm_nxt = imm_nxt;
            end
            S_T1: begin
                ra_out_nxt  = 1'b1;
                rz_in_nxt   = 1'b1;
                add_imm_nxt = imm_nxt;
            end
            S_T2: begin
                rz_out_nxt = 1'b1;
                rb_in_nxt  = 1'b1;
            end
            S_DONE: begin
                done_nxt = 1'b1;
            end
            default: begin
                ready_nxt = 1'b0;
            end
        endcase
    end

    // Only one source may drive the shared bus in any cycle.
    a_bus_onehot: assert property (@(posedge clk) disable iff (clear)
        $onehot0({RAout, RBout, RZout}));

endmodule

// File: tb/tb_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ctrl_sequencer
//
// Stimulus pushes the expected per-cycle output vectors of every accepted
// operation into a queue. A monitor pops one entry for each busy cycle
// (ready=0) and compares the full output bundle. In idle cycles it checks
// that everything is quiet. Timing, reset and abort behaviour get direct
// checks in the stimulus thread.
// ---------------------------------------------------------------------------
module tb_ctrl_sequencer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clear;
    logic          start;
    logic [1:0]    opcode;
    logic [DW-1:0] imm;
`ifdef CTRL_SEQ_STEP_EN
    logic          step;
`endif
    logic          ready;
    logic [DW-1:0] RegisterAImmediate;
    logic [DW-1:0] AddImmediate;
    logic          RAout, RBout, RZout;
    logic          RAin, RBin, RZin;
    logic          done;

    always #5 clk = ~clk;

    ctrl_sequencer #(.DATA_W(DW)) dut (
        .clk                (clk),
        .clear              (clear),
        .start              (start),
        .opcode             (opcode),
`ifdef CTRL_SEQ_STEP_EN
        .step               (step),
`endif
        .imm                (imm),
        .ready              (ready),
        .RegisterAImmediate (RegisterAImmediate),
        .AddImmediate       (AddImmediate),
        .RAout              (RAout),
        .RBout              (RBout),
        .RZout              (RZout),
        .RAin               (RAin),
        .RBin               (RBin),
        .RZin               (RZin),
        .done               (done)
    );

    // en vector order: {RAin, RBin, RZin, RAout, RBout, RZout, done}
    localparam logic [6:0] EN_T0   = 7'b100_000_0;
    localparam logic [6:0] EN_T1   = 7'b001_100_0;
    localparam logic [6:0] EN_T2   = 7'b010_001_0;
    localparam logic [6:0] EN_DONE = 7'b000_000_1;

    typedef struct packed {
        logic [6:0]    en;
        logic [DW-1:0] rai;
        logic [DW-1:0] ai;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    wire [6:0]        en_act  = {RAin, RBin, RZin, RAout, RBout, RZout, done};
    wire [6+2*DW:0]   out_act = {en_act, RegisterAImmediate, AddImmediate};

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [6:0] en, input logic [DW-1:0] rai,
                                input logic [DW-1:0] ai);
        exp_t e;
        e.en  = en;
        e.rai = rai;
        e.ai  = ai;
        return e;
    endfunction

    task automatic push_op(input logic [1:0] op, input logic [DW-1:0] v);
        case (op)
            2'b00: sb.push_back(mk(EN_T0, v, '0));
            2'b01: sb.push_back(mk(EN_T1, '0, v));
            2'b10: sb.push_back(mk(EN_T2, '0, '0));
            default: begin
                sb.push_back(mk(EN_T0, v, '0));
                sb.push_back(mk(EN_T1, '0, v));
                sb.push_back(mk(EN_T2, '0, '0));
            end
        endcase
        sb.push_back(mk(EN_DONE, '0, '0));
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (ready === 1'b1) begin
            check("idle_quiet", 80'(out_act), 80'd0);
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: DUT busy with en=%b, expected no activity (t=%0t)",
                     en_act, $time);
        end else begin
            e = sb.pop_front();
            check("seq_step", 80'(out_act), 80'(e));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, expected 1", ready, n);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [DW-1:0] v);
        wait_ready();
        start  = 1'b1;
        opcode = op;
        imm    = v;
        push_op(op, v);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts busy cycles after the accept edge until done is seen.
    task automatic measure_done(input string name, input int exp_n);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 10);
        check(name, 80'(n), 80'(exp_n));
    endtask

    initial begin
        start  = 1'b1;
        opcode = 2'b00;
        imm    = 32'h33;
        clear  = 1'b0;
`ifdef CTRL_SEQ_STEP_EN
        step   = 1'b1;
`endif
        #1 clear = 1'b1;
        #1;
        check("reset_outputs", 80'({ready, out_act}), 80'({1'b1, 71'd0}));

        // clear held with start=1: nothing may be accepted
        repeat (3) @(negedge clk);
        check("clear_no_accept", 80'({ready, en_act}), 80'({1'b1, 7'd0}));

        // release clear; start still high -> accept on the very next edge
        push_op(2'b00, 32'h33);
        clear = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        check("accept_after_clear", 80'({RAin, RegisterAImmediate}), 80'({1'b1, 32'h33}));

        issue(2'b00, 32'h5);
        measure_done("lda_latency", 2);
        issue(2'b01, 32'h1234);
        measure_done("addi_latency", 2);
        issue(2'b10, 32'h77);
        measure_done("movzb_latency", 2);
        issue(2'b11, 32'h5);
        measure_done("chain_latency", 4);

        // CHAIN with a stray LDA start held through T0 and T1: must be ignored
        issue(2'b11, 32'hC0FFEE);
        start  = 1'b1;
        opcode = 2'b00;
        imm    = 32'hAA;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        wait_ready();

        // back-to-back LDA with start held: re-accept 3 cycles apart
        wait_ready();
        start  = 1'b1;
        opcode = 2'b00;
        imm    = 32'h11;
        push_op(2'b00, 32'h11);
        push_op(2'b00, 32'h22);
        @(posedge clk);
        @(posedge clk);
        #1 imm = 32'h22;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_reaccept", 80'({RAin, RegisterAImmediate}), 80'({1'b1, 32'h22}));
        wait_ready();

        // clear during T1 of CHAIN: immediate abort, no T2, no done
        issue(2'b11, 32'h9);
        @(posedge clk);
        @(negedge clk);
        #2 clear = 1'b1;
        sb.delete();
        #1 check("clear_abort_outputs", 80'({ready, out_act}), 80'({1'b1, 71'd0}));
        @(negedge clk);
        #2 clear = 1'b0;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done === 1'b1 || RZout === 1'b1) seen = 1'b1;
            end
            check("no_done_after_abort", 80'(seen), 80'd0);
        end

        // all-ones immediate through the adder path
        issue(2'b01, 32'hFFFF_FFFF);
        measure_done("addi_ones_latency", 2);

`ifdef CTRL_SEQ_STEP_EN
        // ADDI held in T1 for three step=0 edges, then released
        wait_ready();
        step   = 1'b0;
        start  = 1'b1;
        opcode = 2'b01;
        imm    = 32'h42;
        repeat (4) sb.push_back(mk(EN_T1, '0, 32'h42));
        sb.push_back(mk(EN_DONE, '0, '0));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 step = 1'b1;
        measure_done("step_release", 2);
        wait_ready();
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 80'(sb.size()), 80'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
